// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package im_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * 8;
  localparam int IM_ADDR_W      = 13;

endpackage

// File: rtl/im_word_packer.sv
// Big-endian byte-to-word shift register with a byte counter.
// Latency: word/full reflect the byte being shifted in this cycle.
// Backpressure: none; the caller gates shift_en with its own handshake.
module im_word_packer
  import im_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              full
);

  logic [WORD_W-1:0] sr;
  logic [1:0]        cnt;

  // word is the post-shift value so the owner can capture it on the completing edge
  assign word = shift_en ? {sr[WORD_W-9:0], byte_in} : sr;
  assign full = shift_en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word;
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Streams host bytes into consecutive IM words and holds the CPU while loading.
// Latency: im_we one cycle after the 4th byte handshake; one word per 5 cycles.
// Backpressure: byte_ready only in RECV; bytes in other states stay pending at the host.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int BASE   = 0,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned         MAX_LEN_I = DEPTH - BASE;
  localparam logic [ADDR_W:0]     MAX_LEN   = (ADDR_W + 1)'(MAX_LEN_I);
  localparam logic [ADDR_W-1:0]   BASE_A    = ADDR_W'(BASE);

  ld_state_t         state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] idx;
  logic              shift_en;
  logic              pk_clr;
  logic [WORD_W-1:0] pk_word;
  logic              pk_full;

  assign shift_en = byte_valid && byte_ready;
  assign pk_clr   = (state == IDLE);
  assign cpu_hold = busy;

  im_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .shift_en (shift_en),
    .byte_in  (byte_data),
    .word     (pk_word),
    .full     (pk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      idx        <= '0;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      im_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= DONE;
              busy  <= 1'b1;
              done  <= 1'b1;
            end else if (len > MAX_LEN) begin
              err <= 1'b1;
            end else begin
              len_q      <= len;
              idx        <= '0;
              state      <= RECV;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        RECV: begin
          if (pk_full) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            im_we      <= 1'b1;
            im_addr    <= BASE_A + idx;
            im_wdata   <= pk_word;
          end
        end
        WRITE: begin
          // len_q is at least 1 here, so len_q-1 cannot underflow
          if ({1'b0, idx} == len_q - (ADDR_W + 1)'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            idx        <= idx + ADDR_W'(1);
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
